converter_arbiter: RTL
======================

// Module: converter_arbiter
// PURPOSE
//  Shares one combinational 4-bit code converter (inputs a,b,c,d / outputs x,y,z,t)
//  between two requesters. Round-robin grants one request at a time, drives the code
//  onto the converter and holds it SETTLE_CYCLES clocks. It then samples the converter
//  output and returns it, tagged with the requester id, over a valid/ready response port.
// PARAMETERS
//  SETTLE_CYCLES  2  clocks conv_in is held stable before conv_out is sampled; legal range 1..15
//  CNT_W          4  settle-counter width; must hold SETTLE_CYCLES
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  req0_valid  in   1  requester 0 has a code to convert
//  req0_code   in   4  requester 0 code; bit3=a .. bit0=d
//  req0_ready  out  1  requester 0 accepted this cycle when valid&ready
//  req1_valid  in   1  requester 1 has a code to convert
//  req1_code   in   4  requester 1 code
//  req1_ready  out  1  requester 1 accepted this cycle when valid&ready
//  conv_in     out  4  to converter {a,b,c,d}; registered
//  conv_out    in   4  from converter {x,y,z,t}
//  rsp_valid   out  1  response holding a converted code
//  rsp_ready   in   1  consumer takes response when valid&ready
//  rsp_code    out  4  converted code, stable while rsp_valid
//  rsp_id      out  1  requester that owns rsp_code
//  busy        out  1  state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, conv_in=0, rsp_valid=0, rsp_code=0, rsp_id=0,
//   last_grant=1 (requester 0 wins first tie), counter=0, busy=0. req*_ready are
//   combinational; reset drives them 0 with state=IDLE and no valid.
//  FSM IDLE -> SETTLE -> RESP -> IDLE:
//   IDLE:   grant = sole valid requester; if both valid, the one != last_grant.
//           req<g>_ready=1 only in IDLE and only for the granted requester. On accept:
//           conv_in<=code, rsp_id<=g, last_grant<=g, cnt<=SETTLE_CYCLES-1, go SETTLE.
//   SETTLE: cnt decrements each clock; when cnt==0: rsp_code<=conv_out, rsp_valid<=1, go RESP.
//   RESP:   hold rsp_*; when rsp_ready: rsp_valid<=0, go IDLE.
//  Latency: accept at edge N -> rsp_valid high after edge N+SETTLE_CYCLES
//   (SETTLE_CYCLES=2: accept edge 0, rsp_valid visible after edge 2).
//  Throughput: one conversion per SETTLE_CYCLES+2 clocks minimum (no bypass RESP->accept).
//  conv_in holds the last granted code until the next accept; it never changes in SETTLE/RESP.
//  Requester may drop valid before ready: no grant, no state change. The code is sampled
//   only in the accept cycle.
//  Valid arriving outside IDLE waits; ready stays 0.
//  rsp_ready held high at RESP entry: response lasts exactly one cycle.
//  Async reset mid-SETTLE or mid-RESP: the in-flight conversion is dropped silently, no response.
//  No arithmetic beyond the counter; counter never wraps (reloaded on accept only).
// STRUCTURE
//  converter_pkg: state enum {IDLE,SETTLE,RESP} (2-bit), REQ0/REQ1 id constants, CODE_W=4.
//  Sub-module rr_arb2: 2-way round-robin (valid0, valid1, last_grant -> grant, any);
//   pure combinational. The FSM, counter and datapath registers stay in converter_arbiter.
// TESTING  (bench stubs converter as Gray model: conv_out = conv_in ^ (conv_in>>1))
//  1 reset: rst_n=0 mid-run -> all outputs 0 same cycle, busy=0, no rsp after release.
//  2 single: req0 code 4'b0110, rsp_ready=1 -> rsp_valid 2 clocks after accept,
//    rsp_code=4'b0101, rsp_id=0.
//  3 tie: both valid (req0 4'b1111, req1 4'b1000) held -> grant order 0,1,0,1;
//    rsp codes 4'b1000, 4'b1100 alternate.
//  4 backpressure: rsp_ready=0 for 5 clocks -> rsp_valid, rsp_code, conv_in held;
//    req1_ready stays 0; release -> one response.
//  5 sweep: req1 drives all 16 codes 0..15 in order -> 16 responses, each = Gray(code),
//    spacing SETTLE_CYCLES+2 clocks.
//  6 abort: assert rst_n=0 during SETTLE of code 4'b0011 -> no response; next req0 4'b0001
//    -> rsp_code 4'b0001, rsp_id=0.

Source files
------------

// File: rtl/converter_pkg.sv
// Shared types and constants for the converter arbiter slice.
package converter_pkg;

    localparam int CODE_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/converter_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: picks the sole requester, or on a tie the one
// that did not win last time.
module rr_arb2
    import converter_pkg::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_any
);

    assign o_any   = i_valid0 | i_valid1;
    assign o_grant = (i_valid0 && i_valid1) ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/converter_arbiter.sv
// Time-shares one combinational code converter between two requesters and
// returns each sampled result, tagged with its owner, on a valid/ready port.
module converter_arbiter
    import converter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req0_valid,
    input  logic [CODE_W-1:0] i_req0_code,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [CODE_W-1:0] i_req1_code,
    output logic              o_req1_ready,
    output logic [CODE_W-1:0] o_conv_in,
    input  logic [CODE_W-1:0] i_conv_out,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [CODE_W-1:0] o_rsp_code,
    output logic              o_rsp_id,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CODE_W-1:0]   r_conv_in;
    logic [CODE_W-1:0]   r_rsp_code;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic                r_last_grant;

    logic                w_grant;
    logic                w_any;
    logic                w_idle;

    rr_arb2 u_arb (
        .i_valid0     (i_req0_valid),
        .i_valid1     (i_req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any        (w_any)
    );

    assign w_idle       = (r_state == IDLE);
    // Ready is offered only to the winner, and only while the converter is free.
    assign o_req0_ready = w_idle && w_any && (w_grant == REQ0);
    assign o_req1_ready = w_idle && w_any && (w_grant == REQ1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_conv_in    <= '0;
            r_rsp_code   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= REQ0;
            r_last_grant <= REQ1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_conv_in    <= w_grant ? i_req1_code : i_req0_code;
                        r_rsp_id     <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= CNT_LOAD;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    // conv_in has been stable SETTLE_CYCLES clocks once cnt reaches 0.
                    if (r_cnt == '0) begin
                        r_rsp_code  <= i_conv_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_conv_in   = r_conv_in;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_code  = r_rsp_code;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = (r_state != IDLE);

endmodule
